// File: rtl/pulse_scheduler_pkg.sv
// Shared state encoding and default field widths for the pulse scheduler.
// No logic; constants only. No flow control.
package pulse_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int DEF_WW = 4;
    localparam int DEF_GW = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among active requesters, search starting at ptr.
// Latency: purely combinational. Backpressure: none; caller decides when to use gnt.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx
);

    always_comb begin
        logic found;
        int   cand;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NREQ)
                cand = cand - NREQ;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/pulse_scheduler.sv
// Shares one pulse generator among NREQ requesters, one pulse of per-requester width at a time.
// Latency: req sampled at edge k drives pulse high after edge k; optional guard gap after each pulse.
// Backpressure: req is a level; it is ignored while PULSE or GAP is in progress.
module pulse_scheduler
    import pulse_scheduler_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int WW   = DEF_WW,
    parameter int GW   = DEF_GW
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*WW-1:0] width_i,
    input  logic [GW-1:0]    gap_i,
    output logic [NREQ-1:0]  grant,
    output logic             pulse,
    output logic [NREQ-1:0]  done,
    output logic             busy
);

    localparam int CW = (WW > GW) ? WW : GW;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   owner;
    logic [NREQ-1:0] arb_gnt;
    logic [PW-1:0]   arb_idx;
    logic [WW-1:0]   w_sel;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req (req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign w_sel = width_i[arb_idx*WW +: WW];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            count  <= '0;
            rr_ptr <= '0;
            owner  <= '0;
            grant  <= '0;
            pulse  <= 1'b0;
            done   <= '0;
            busy   <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (req != '0) begin
                        // Zero width behaves as a single-cycle pulse.
                        count <= (w_sel == '0) ? '0 : CW'(w_sel - WW'(1));
                        owner <= arb_idx;
                        grant <= arb_gnt;
                        pulse <= 1'b1;
                        busy  <= 1'b1;
                        state <= PULSE;
                    end
                end
                PULSE: begin
                    if (count == '0) begin
                        pulse  <= 1'b0;
                        done   <= grant;
                        grant  <= '0;
                        rr_ptr <= (int'(owner) == NREQ - 1) ? '0 : owner + PW'(1);
                        if (gap_i != '0) begin
                            count <= CW'(gap_i - GW'(1));
                            state <= GAP;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                GAP: begin
                    if (count == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                default: begin
                    grant <= '0;
                    pulse <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed stimulus with an expected-pulse scoreboard checked by an independent monitor.
module tb_pulse_scheduler;

    localparam int NREQ = 4;
    localparam int WW   = 4;
    localparam int GW   = 3;

    logic              clock;
    logic              reset_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*WW-1:0] width_i;
    logic [GW-1:0]     gap_i;
    logic [NREQ-1:0]   grant;
    logic              pulse;
    logic [NREQ-1:0]   done;
    logic              busy;

    pulse_scheduler #(.NREQ(NREQ), .WW(WW), .GW(GW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .width_i (width_i),
        .gap_i   (gap_i),
        .grant   (grant),
        .pulse   (pulse),
        .done    (done),
        .busy    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int owner;
        int width;
        int spacing;   // low cycles since previous pulse; -1 means unchecked
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_rise   = 0;
    int   n_done   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++)
            if (v[i]) r = i;
        return r;
    endfunction

    // Monitor: measures each pulse and scores it against the queue when done strobes.
    initial begin
        bit in_pulse;
        int cur_owner, cur_w, cur_spacing, low_cnt;
        exp_t e;
        in_pulse = 0; cur_owner = -1; cur_w = 0; cur_spacing = 0; low_cnt = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                in_pulse = 0;
                low_cnt  = 0;
            end else begin
                check("grant_onehot0", 32'($countones(grant) <= 1), 1);
                check("done_onehot0", 32'($countones(done) <= 1), 1);
                if (pulse) check("pulse_has_grant", 32'(grant != '0), 1);
                if (pulse) begin
                    if (!in_pulse) begin
                        in_pulse    = 1;
                        cur_owner   = onehot_idx(grant);
                        cur_w       = 0;
                        cur_spacing = low_cnt;
                        n_rise++;
                    end
                    cur_w++;
                end else begin
                    if (done != '0) begin
                        n_done++;
                        check("done_on_fall", 32'(in_pulse), 1);
                        check("done_expected", 32'(sb.size() != 0), 1);
                        if (sb.size() != 0) begin
                            e = sb.pop_front();
                            check("owner", cur_owner, e.owner);
                            check("width", cur_w, e.width);
                            check("done_bit", 32'(done), 32'(1 << e.owner));
                            if (e.spacing >= 0) check("spacing", cur_spacing, e.spacing);
                        end
                        low_cnt = 0;
                    end else if (in_pulse) begin
                        check("fall_without_done", 0, 1);
                    end
                    in_pulse = 0;
                    low_cnt++;
                end
            end
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_rise(input int target);
        for (int c = 0; c < 200 && n_rise < target; c++) step();
        check("timeout_rise", 32'(n_rise >= target), 1);
    endtask

    task automatic wait_done(input int target);
        for (int c = 0; c < 200 && n_done < target; c++) step();
        check("timeout_done", 32'(n_done >= target), 1);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 200 && busy; c++) step();
        check("timeout_idle", 32'(busy), 0);
        step();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        int rb, db;
        bit seen;
        reset_n = 1'b0;
        req     = '0;
        width_i = '0;
        gap_i   = '0;
        step();
        step();
        reset_n = 1'b1;

        // Idle after reset release.
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_outputs", 32'({grant, pulse, done, busy}), 0);
        end

        // Single requester, width 8, no gap, back-to-back with req held.
        rb = n_rise; db = n_done;
        width_i[0*WW +: WW] = 4'd8;
        gap_i = 3'd0;
        sb.push_back('{0, 8, -1});
        sb.push_back('{0, 8, 1});
        req = 4'b0001;
        step();
        check("latency_pulse", 32'(pulse), 1);
        check("latency_grant", 32'(grant), 32'h1);
        wait_rise(rb + 2);
        req = '0;
        wait_done(db + 2);
        wait_idle();

        // Round robin from a fresh pointer.
        do_reset();
        rb = n_rise; db = n_done;
        for (int i = 0; i < NREQ; i++) width_i[i*WW +: WW] = 4'd2;
        gap_i = 3'd1;
        sb.push_back('{0, 2, -1});
        sb.push_back('{1, 2, 2});
        sb.push_back('{2, 2, 2});
        sb.push_back('{3, 2, 2});
        sb.push_back('{0, 2, 2});
        req = 4'b1111;
        wait_rise(rb + 5);
        req = '0;
        wait_done(db + 5);
        wait_idle();

        // Width 0 and maximum width.
        gap_i = 3'd0;
        width_i[1*WW +: WW] = 4'd0;
        width_i[2*WW +: WW] = 4'd15;
        rb = n_rise; db = n_done;
        sb.push_back('{1, 1, -1});
        req = 4'b0010;
        wait_rise(rb + 1);
        req = '0;
        wait_done(db + 1);
        wait_idle();
        rb = n_rise; db = n_done;
        sb.push_back('{2, 15, -1});
        req = 4'b0100;
        wait_rise(rb + 1);
        req = '0;
        wait_done(db + 1);
        wait_idle();

        // Mid-pulse disturbance on requester 3.
        width_i[3*WW +: WW] = 4'd6;
        width_i[1*WW +: WW] = 4'd3;
        rb = n_rise; db = n_done;
        sb.push_back('{3, 6, -1});
        sb.push_back('{1, 3, 1});
        req = 4'b1000;
        wait_rise(rb + 1);
        req = 4'b0010;
        width_i[3*WW +: WW] = 4'd2;
        wait_rise(rb + 2);
        req = '0;
        wait_done(db + 2);
        wait_idle();

        // Gap sampled at pulse end; later changes ignored.
        width_i[2*WW +: WW] = 4'd4;
        gap_i = 3'd3;
        rb = n_rise;
        sb.push_back('{2, 4, -1});
        req = 4'b0100;
        wait_rise(rb + 1);
        req = '0;
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            step();
            if (done != '0) seen = 1;
        end
        check("gap_done_seen", 32'(seen), 1);
        check("gap_cycle1", 32'({busy, pulse}), 32'h2);
        gap_i = 3'd0;
        step();
        check("gap_cycle2", 32'({busy, pulse}), 32'h2);
        step();
        check("gap_cycle3", 32'({busy, pulse}), 32'h2);
        step();
        check("gap_end_idle", 32'({busy, pulse}), 32'h0);

        // Reset asserted mid-pulse.
        width_i[0*WW +: WW] = 4'd10;
        rb = n_rise;
        req = 4'b0001;
        wait_rise(rb + 1);
        req = '0;
        step();
        step();
        check("pre_reset_pulse", 32'(pulse), 1);
        reset_n = 1'b0;
        #1;
        check("rst_pulse", 32'(pulse), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_no_done", 32'(done), 0);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_idle", 32'({grant, pulse, done, busy}), 0);
        end

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_scheduler.md
Name: pulse_scheduler

Overview:
- Shares one pulse generator among NREQ requesters; each requester supplies its own pulse width.
- Round-robin arbitration picks one requester at a time. The block then drives a single pulse of that width, measured in clock cycles.
- An optional programmable guard gap follows each pulse.
- Sits between the free-running clock generator and downstream blocks that need timed, clock-synchronised marking pulses.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WW, 4, width of each per-requester pulse-length field in cycles.
- GW, 3, width of the guard-gap field in cycles.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NREQ  level request, one bit per requester.
- width_i  in  NREQ*WW  packed pulse lengths; field i is bits [i*WW +: WW].
- gap_i  in  GW  guard cycles after each pulse.
- grant  out  NREQ  one-hot owner of the current pulse; all zero when idle.
- pulse  out  1  shared pulse output.
- done  out  NREQ  one-cycle strobe to the owner when its pulse ends.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Interface is fixed: one clock; reset is asynchronous and active-low.
- Reset (reset_n=0, applied asynchronously):
  - grant=0, pulse=0, done=0, busy=0.
  - state=IDLE, count=0, rr pointer=0.
  - Reset asserted mid-pulse truncates the pulse immediately; no done strobe is issued.
- All outputs are registered.
- State IDLE:
  - On a posedge with req!=0, choose the winner by round robin, starting the search at the rr pointer.
  - Latch the winner's width field; a width of 0 is treated as 1.
  - Set grant to the winner's one-hot code and set pulse=1, busy=1; go to PULSE.
  - Latency: req sampled high at edge k means pulse is high after edge k.
- State PULSE:
  - pulse stays high for exactly W cycles, W being the latched width (1..2^WW-1).
  - count loads W-1 on entry and decrements each cycle.
  - On the edge where count==0: pulse=0, done[winner]=1 for one cycle, grant cleared, rr pointer=winner+1 (mod NREQ).
  - Then go to GAP if gap_i!=0, otherwise IDLE.
- State GAP:
  - pulse=0 and busy=1 for exactly G cycles, G = gap_i sampled at the end of the pulse; return to IDLE.
- Back-to-back operation:
  - In IDLE, a new grant may occur on the first edge after GAP or PULSE ends.
  - Minimum pulse-to-pulse spacing is therefore G+1 low cycles, or 1 low cycle when G=0.
- Request rules:
  - req is not re-sampled during PULSE or GAP.
  - Deasserting req mid-pulse does not abort the pulse; done is still strobed.
  - A requester holding req high is re-granted only after the others have had their turn (fairness).
- Configuration timing:
  - width_i changes during PULSE have no effect.
  - gap_i is used only at the PULSE-to-GAP transition.
- Invariants:
  - grant has at most one bit set.
  - pulse=1 implies grant!=0.
  - done has at most one bit set and coincides with pulse falling.
- Count width is max(WW,GW) bits; there is no wrap-around, because count never decrements below 0.

Decomposition:
- Shared constants live in a common include: state encodings IDLE=2'd0, PULSE=2'd1, GAP=2'd2, plus the default WW/GW.
- Sub-module rr_arbiter(NREQ):
  - Purely combinational.
  - Inputs: req, ptr.
  - Outputs: one-hot gnt and binary index idx.
  - Instantiated once.
- The FSM, counter and pointer stay in pulse_scheduler.

Test Plan:
- Reset release, req=0 for 10 cycles: grant=0, pulse=0, busy=0, done=0 throughout. Then assert reset_n=0 mid-pulse: pulse and grant drop within the same time step, no done.
- Single requester: req=4'b0001, width0=8, gap=0. pulse high for exactly 8 cycles, starting the cycle after req is sampled; done[0] strobes on the falling cycle; with req held, the next pulse starts after 1 low cycle.
- Round robin: req=4'b1111, all widths=2, gap=1. Grant order is 0,1,2,3,0; every pulse is 2 cycles long, separated by 2 low cycles (1 gap cycle + 1 IDLE cycle).
- Width 0 and maximum width: width1=0 gives a 1-cycle pulse; width2=15 gives a 15-cycle pulse. done strobes once for each.
- Mid-pulse disturbance: while requester 3 holds a pulse of width 6, drop req[3], raise req[1], and change width3 to 2. The pulse still lasts 6 cycles and done[3] fires; requester 1 is granted next.
- Gap sampling: gap=3 at the end of the pulse, changed to 0 during GAP. Exactly 3 GAP cycles with busy=1 and pulse=0, then IDLE.
